// File: rtl/snn_mem_pkg.sv
// snn_mem_pkg: shared types and default sizes for the synaptic weight memory
// port and its update controller.
//   wu_state_e : weight-update sweep FSM states (IDLE, RD, WB, DONE)
//   WU_ADDR_W  : default weight-memory address width
//   WU_DW      : default weight width
//   weight_t   : weight word at the default width
package snn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WB,
    DONE
  } wu_state_e;

  localparam int unsigned WU_ADDR_W = 4;
  localparam int unsigned WU_DW     = 8;

  typedef logic [WU_DW-1:0] weight_t;

endpackage

// File: rtl/weight_update_alu.sv
// weight_update_alu: combinational reward-driven weight update.
//   new_weight = weight + (reward >>> SHIFT), where weight is unsigned and
//   reward is signed.
// Build option: define WU_SATURATE_EN to clamp the result to [0, 2^DW-1].
// Without it the result wraps modulo 2^DW.
// Ports:
//   weight     in  DW : current (unsigned) weight
//   reward     in  DW : signed reward
//   new_weight out DW : updated weight
module weight_update_alu #(
  parameter int unsigned DW    = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic [DW-1:0] weight,
  input  logic [DW-1:0] reward,
  output logic [DW-1:0] new_weight
);

  logic signed [DW-1:0] delta;

`ifdef WU_SATURATE_EN
  logic signed [DW+1:0] sum;

  always_comb begin
    delta = $signed(reward) >>> SHIFT;
    // Two guard bits: zero-extended weight plus sign-extended delta cannot
    // overflow DW+2 signed bits, so the top bits cleanly flag under/overflow.
    sum   = $signed({2'b00, weight}) + $signed({{2{delta[DW-1]}}, delta});
    if (sum[DW+1]) begin
      new_weight = '0;
    end else if (sum[DW]) begin
      new_weight = '1;
    end else begin
      new_weight = sum[DW-1:0];
    end
  end
`else
  // The wrapping result is the low DW bits of the wide sum, which is exactly
  // a DW-bit modular add.
  always_comb begin
    delta      = $signed(reward) >>> SHIFT;
    new_weight = weight + delta;
  end
`endif

endmodule

// File: rtl/weight_update_ctrl.sv
// weight_update_ctrl: reward-driven sweep over the synaptic weight memory.
// On an accepted start, every address is read (RD) and, if eligible, written
// back with weight + (reward >>> SHIFT) (WB). done pulses after the last WB.
// Saturating vs wrapping arithmetic is chosen by WU_SATURATE_EN inside
// weight_update_alu.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : sweep request (ignored unless idle or in DONE)
//   reward [DW]         : signed reward, latched on accept
//   elig [2^ADDR_W]     : per-address eligibility, latched on accept
//   busy, done          : sweep in progress / one-cycle completion pulse
//   upd_count [ADDR_W+1]: writes performed in the last sweep
//   mem_we, mem_addr, mem_wdata, mem_rdata : weight memory port
//                         (one-cycle registered read)
module weight_update_ctrl
  import snn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = WU_ADDR_W,
  parameter int unsigned DW     = WU_DW,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DW-1:0]        reward,
  input  logic [(1<<ADDR_W)-1:0] elig,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      upd_count,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  wu_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]       reward_q, reward_d;
  logic [DEPTH-1:0]    elig_q, elig_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     upd_q, upd_d;
  logic [DW-1:0]       new_w;
  logic                accept;

  weight_update_alu #(
    .DW   (DW),
    .SHIFT(SHIFT)
  ) u_alu (
    .weight    (mem_rdata),
    .reward    (reward_q),
    .new_weight(new_w)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reward_d = reward_q;
    elig_d   = elig_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    upd_d    = upd_q;
    // DONE is the last cycle before IDLE, so a start there is taken directly.
    accept   = start && (state_q == IDLE || state_q == DONE);

    unique case (state_q)
      IDLE: ;
      RD: begin
        state_d = WB;
        // Eligibility is known ahead of the read data, so the enable for the
        // coming WB cycle can be registered here.
        we_d    = elig_q[cnt_q];
      end
      WB: begin
        we_d = 1'b0;
        if (elig_q[cnt_q]) begin
          upd_d = upd_q + (ADDR_W+1)'(1);
        end
        if (cnt_q == '1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          addr_d  = cnt_q + ADDR_W'(1);
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = RD;
      reward_d = reward;
      elig_d   = elig;
      cnt_d    = '0;
      addr_d   = '0;
      upd_d    = '0;
      busy_d   = 1'b1;
      we_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reward_q <= '0;
      elig_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      upd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reward_q <= reward_d;
      elig_q   <= elig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      upd_q    <= upd_d;
    end
  end

  // Read data only arrives during WB, so write data is the one memory output
  // taken straight from mem_rdata through the ALU; it is forced to zero
  // outside WB (including under reset).
  always_comb begin
    mem_wdata = '0;
    if (state_q == WB) begin
      mem_wdata = elig_q[cnt_q] ? new_w : mem_rdata;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign upd_count = upd_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;

endmodule
